audio_mode_sequencer: RTL and testbench

Sequences changes of the voice-effect control word (gender shift, denoise, separation, mute, speaker routing) coming from the UART local-bus register file into the audio datapath. No control bit ever changes while audio is audible. Each change runs in order: fade the output gain to zero, apply the new controls, flush the processing pipeline for a fixed number of samples, then fade back in. It sits between the register outputs and the effect/speaker datapath, in the clk48m domain.

---
 rtl/audio_mode_sequencer.sv | 148 ++++++++++++++
 tb/tb_audio_mode_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mode_sequencer.sv
// Sequences voice-effect control-word changes into the audio datapath: fade out, apply, flush, fade in.
// Define AMS_FADE_EN for linear gain ramps; otherwise gain drops to 0 at once and restores on one sample.
module audio_mode_sequencer #(
  parameter int GAIN_W         = 8,
  parameter int FADE_STEP      = 8,
  parameter int SETTLE_SAMPLES = 64
) (
  input  logic              clk48m,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              req_boy2girl,
  input  logic              req_girl2boy,
  input  logic              req_denoise,
  input  logic              req_separate1,
  input  logic              req_separate2,
  input  logic              req_mute,
  input  logic [2:0]        req_speaker,
  output logic              cur_boy2girl,
  output logic              cur_girl2boy,
  output logic              cur_denoise,
  output logic              cur_separate1,
  output logic              cur_separate2,
  output logic              cur_mute,
  output logic [2:0]        cur_speaker,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              switch_done,
  output logic              conflict,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {RUN = 2'd0, FADE_OUT = 2'd1, FLUSH = 2'd2, FADE_IN = 2'd3} state_t;

  localparam int CNT_W  = $clog2(SETTLE_SAMPLES + 1);
  localparam int GMAX_I = (1 << GAIN_W) - 1;
`ifdef AMS_FADE_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  // Without ramps a step of GMAX reaches either end of the gain range in one move.
  localparam int                STEP     = RAMP ? FADE_STEP : GMAX_I;
  localparam logic [GAIN_W:0]   STEP_W   = (GAIN_W + 1)'(STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_SAMPLES - 1);

  state_t             state, state_n;
  logic [8:0]         req_q, p_word, cur_q, cur_n;
  logic [GAIN_W-1:0]  gain_n, target, gain_up, gain_dn, out_gain, in_gain;
  logic [GAIN_W:0]    gain_x, target_x, up_sum, dn_diff;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               done_n, out_adv;

  // Word layout: {speaker[2:0], mute, separate2, separate1, denoise, girl2boy, boy2girl}
  assign p_word = (req_q[0] & req_q[1]) ? {req_q[8:2], 2'b00} : req_q;
  assign target = cur_q[5] ? '0 : '1;

  assign gain_x   = {1'b0, gain};
  assign target_x = {1'b0, target};
  assign up_sum   = gain_x + STEP_W;
  assign dn_diff  = gain_x - STEP_W;
  assign gain_up  = (up_sum >= target_x) ? target : up_sum[GAIN_W-1:0];
  assign gain_dn  = (gain_x > STEP_W) ? dn_diff[GAIN_W-1:0] : '0;

  // Without ramps the fade-out does not wait for a sample strobe.
  assign out_adv  = sample_en | ~RAMP;
  assign out_gain = out_adv ? gain_dn : gain;
  assign in_gain  = sample_en ? gain_up : gain;

  always_comb begin
    state_n = state;
    gain_n  = gain;
    cnt_n   = cnt;
    cur_n   = cur_q;
    done_n  = 1'b0;
    case (state)
      RUN: begin
        gain_n = target;
        if (p_word != cur_q) state_n = FADE_OUT;
      end
      FADE_OUT: begin
        gain_n = out_gain;
        // Controls move on the same edge that gain lands on zero.
        if (out_gain == '0) begin
          cur_n   = p_word;
          cnt_n   = '0;
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        gain_n = '0;
        if (p_word != cur_q) begin
          cur_n = p_word;
          cnt_n = '0;
        end else if (sample_en) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = FADE_IN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      FADE_IN: begin
        if (p_word != cur_q) begin
          state_n = FADE_OUT;
        end else begin
          gain_n = in_gain;
          if (in_gain == target) begin
            state_n = RUN;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = FLUSH;
    endcase
  end

  always_ff @(posedge clk48m) begin
    if (reset) begin
      state       <= FLUSH;
      gain        <= '0;
      cnt         <= '0;
      cur_q       <= '0;
      req_q       <= '0;
      busy        <= 1'b1;
      switch_done <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      state       <= state_n;
      gain        <= gain_n;
      cnt         <= cnt_n;
      cur_q       <= cur_n;
      req_q       <= {req_speaker, req_mute, req_separate2, req_separate1,
                      req_denoise, req_girl2boy, req_boy2girl};
      busy        <= (state_n != RUN);
      switch_done <= done_n;
      conflict    <= req_boy2girl & req_girl2boy;
    end
  end

  assign cur_boy2girl  = cur_q[0];
  assign cur_girl2boy  = cur_q[1];
  assign cur_denoise   = cur_q[2];
  assign cur_separate1 = cur_q[3];
  assign cur_separate2 = cur_q[4];
  assign cur_mute      = cur_q[5];
  assign cur_speaker   = cur_q[8:6];
  assign state_dbg     = state;
endmodule

// File: tb/tb_audio_mode_sequencer.sv
// Directed bench for audio_mode_sequencer; expectations follow AMS_FADE_EN when it is defined.
`timescale 1ns/1ps
module tb_audio_mode_sequencer;
`ifdef AMS_FADE_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int FI = RAMP ? 32 : 1;
  localparam logic [1:0] S_RUN = 2'd0, S_FADE_OUT = 2'd1, S_FLUSH = 2'd2, S_FADE_IN = 2'd3;

  logic clk48m = 1'b0, reset = 1'b1, sample_en = 1'b0;
  logic req_boy2girl = 0, req_girl2boy = 0, req_denoise = 0;
  logic req_separate1 = 0, req_separate2 = 0, req_mute = 0;
  logic [2:0] req_speaker = 3'b000;
  logic cur_boy2girl, cur_girl2boy, cur_denoise, cur_separate1, cur_separate2, cur_mute;
  logic [2:0] cur_speaker;
  logic [7:0] gain;
  logic busy, switch_done, conflict;
  logic [1:0] state_dbg;
  logic [8:0] cur_word, prev_cur;
  logic [7:0] exp_q[$];
  int n_vec = 0, n_err = 0, done_cnt = 0, viol_cnt = 0;

  audio_mode_sequencer dut (
    .clk48m(clk48m), .reset(reset), .sample_en(sample_en),
    .req_boy2girl(req_boy2girl), .req_girl2boy(req_girl2boy), .req_denoise(req_denoise),
    .req_separate1(req_separate1), .req_separate2(req_separate2), .req_mute(req_mute),
    .req_speaker(req_speaker),
    .cur_boy2girl(cur_boy2girl), .cur_girl2boy(cur_girl2boy), .cur_denoise(cur_denoise),
    .cur_separate1(cur_separate1), .cur_separate2(cur_separate2), .cur_mute(cur_mute),
    .cur_speaker(cur_speaker), .gain(gain), .busy(busy), .switch_done(switch_done),
    .conflict(conflict), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk48m = ~clk48m;

  assign cur_word = {cur_speaker, cur_mute, cur_separate2, cur_separate1,
                     cur_denoise, cur_girl2boy, cur_boy2girl};

  always @(negedge clk48m) begin
    if (switch_done === 1'b1) done_cnt++;
    if (cur_word !== prev_cur && gain !== 8'd0 && !reset) viol_cnt++;
    prev_cur = cur_word;
  end

  function automatic logic [7:0] exp_up(input int k);
    int v;
    v = RAMP ? 8 * k : 255;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_dn(input int g0, input int k);
    int v;
    v = RAMP ? g0 - 8 * k : 0;
    if (v < 0) v = 0;
    return v[7:0];
  endfunction

  // driver tasks
  task automatic clk_cycle(input logic se);
    sample_en = se;
    @(negedge clk48m);
    sample_en = 1'b0;
  endtask

  task automatic send_sample();
    clk_cycle(1'b1);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
  endtask

  task automatic send_samples(input int n);
    for (int i = 0; i < n; i++) send_sample();
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_samples, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_samples && !ok; i++) begin
      if (state_dbg === s) ok = 1'b1;
      else send_sample();
    end
    if (state_dbg === s) ok = 1'b1;
  endtask

  task automatic full_switch(output bit ok);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    wait_state(S_RUN, 300, ok);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FLUSH) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, S_FLUSH); end
    n_vec++; if (gain !== 8'd0) begin n_err++; $display("FAIL rst_gain: got %0d expected 0", gain); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b expected 1", busy); end
    n_vec++; if (switch_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", switch_done); end
    n_vec++; if (conflict !== 1'b0) begin n_err++; $display("FAIL rst_conflict: got %b expected 0", conflict); end
    n_vec++; if (cur_word !== 9'd0) begin n_err++; $display("FAIL rst_cur: got %h expected 0", cur_word); end
    reset = 1'b0;
    clk_cycle(1'b0);
  endtask

  task automatic test_power_up();
    logic [7:0] e;
    for (int i = 1; i <= 63; i++) begin
      send_sample();
      n_vec++;
      if (gain !== 8'd0 || busy !== 1'b1 || state_dbg !== S_FLUSH) begin
        n_err++; $display("FAIL pu_flush%0d: got gain=%0d busy=%b st=%0d expected 0/1/%0d", i, gain, busy, state_dbg, S_FLUSH);
      end
    end
    clk_cycle(1'b1);
    n_vec++; if (state_dbg !== S_FADE_IN || gain !== 8'd0) begin n_err++; $display("FAIL pu_enter_in: got st=%0d gain=%0d expected %0d/0", state_dbg, gain, S_FADE_IN); end
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    for (int k = 1; k <= FI; k++) exp_q.push_back(exp_up(k));
    for (int k = 1; k <= FI; k++) begin
      e = exp_q.pop_front();
      clk_cycle(1'b1);
      n_vec++; if (gain !== e) begin n_err++; $display("FAIL pu_ramp%0d: got %0d expected %0d", k, gain, e); end
      if (k == FI) begin
        n_vec++; if (switch_done !== 1'b1 || state_dbg !== S_RUN || busy !== 1'b0) begin
          n_err++; $display("FAIL pu_done: got done=%b st=%0d busy=%b expected 1/%0d/0", switch_done, state_dbg, busy, S_RUN);
        end
        clk_cycle(1'b0);
        n_vec++; if (switch_done !== 1'b0) begin n_err++; $display("FAIL pu_done_pulse: got %b expected 0", switch_done); end
        clk_cycle(1'b0);
      end else begin
        clk_cycle(1'b0);
        clk_cycle(1'b0);
      end
    end
  endtask

  task automatic test_denoise();
    bit ok;
    logic [7:0] e;
    req_denoise = 1'b1;
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_RUN) begin n_err++; $display("FAIL dn_latency1: got st=%0d expected %0d", state_dbg, S_RUN); end
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FADE_OUT || gain !== 8'd255 || cur_denoise !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL dn_enter_out: got st=%0d gain=%0d cur=%b busy=%b expected %0d/255/0/1", state_dbg, gain, cur_denoise, busy, S_FADE_OUT);
    end
    for (int k = 1; k <= FI; k++) begin
      e = exp_dn(255, k);
      clk_cycle(RAMP);
      n_vec++; if (gain !== e) begin n_err++; $display("FAIL dn_fade%0d: got %0d expected %0d", k, gain, e); end
      n_vec++; if (cur_denoise !== (k == FI)) begin n_err++; $display("FAIL dn_cur%0d: got %b expected %b", k, cur_denoise, (k == FI)); end
      clk_cycle(1'b0);
      clk_cycle(1'b0);
    end
    send_samples(63);
    n_vec++; if (state_dbg !== S_FLUSH) begin n_err++; $display("FAIL dn_flush63: got st=%0d expected %0d", state_dbg, S_FLUSH); end
    send_sample();
    n_vec++; if (state_dbg !== S_FADE_IN) begin n_err++; $display("FAIL dn_flush64: got st=%0d expected %0d", state_dbg, S_FADE_IN); end
    send_sample();
    n_vec++; if (gain !== exp_up(1)) begin n_err++; $display("FAIL dn_ramp1: got %0d expected %0d", gain, exp_up(1)); end
    wait_state(S_RUN, 100, ok);
    n_vec++; if (!ok || gain !== 8'd255 || cur_denoise !== 1'b1) begin
      n_err++; $display("FAIL dn_back: got ok=%b gain=%0d cur=%b expected 1/255/1", ok, gain, cur_denoise);
    end
  endtask

  task automatic test_conflict();
    bit ok;
    req_boy2girl = 1'b1;
    full_switch(ok);
    n_vec++; if (!ok || cur_boy2girl !== 1'b1 || conflict !== 1'b0) begin
      n_err++; $display("FAIL cf_b2g: got ok=%b cur=%b conflict=%b expected 1/1/0", ok, cur_boy2girl, conflict);
    end
    req_girl2boy = 1'b1;
    clk_cycle(1'b0);
    n_vec++; if (conflict !== 1'b1) begin n_err++; $display("FAIL cf_flag: got %b expected 1", conflict); end
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FADE_OUT) begin n_err++; $display("FAIL cf_start: got st=%0d expected %0d", state_dbg, S_FADE_OUT); end
    wait_state(S_RUN, 300, ok);
    n_vec++; if (!ok || cur_boy2girl !== 1'b0 || cur_girl2boy !== 1'b0 || conflict !== 1'b1) begin
      n_err++; $display("FAIL cf_result: got ok=%b b2g=%b g2b=%b conflict=%b expected 1/0/0/1", ok, cur_boy2girl, cur_girl2boy, conflict);
    end
    req_boy2girl = 1'b0;
    req_girl2boy = 1'b0;
    clk_cycle(1'b0);
    n_vec++; if (conflict !== 1'b0) begin n_err++; $display("FAIL cf_clear: got %b expected 0", conflict); end
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    n_vec++; if (busy !== 1'b0 || state_dbg !== S_RUN) begin n_err++; $display("FAIL cf_noswitch: got busy=%b st=%0d expected 0/%0d", busy, state_dbg, S_RUN); end
  endtask

  task automatic test_flush_restart();
    bit ok;
    req_separate2 = 1'b1;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    wait_state(S_FLUSH, 60, ok);
    n_vec++; if (!ok || cur_separate2 !== 1'b1 || gain !== 8'd0) begin
      n_err++; $display("FAIL fr_flush: got ok=%b cur=%b gain=%0d expected 1/1/0", ok, cur_separate2, gain);
    end
    send_samples(40);
    req_speaker = 3'b010;
    clk_cycle(1'b0);
    n_vec++; if (cur_speaker !== 3'b000) begin n_err++; $display("FAIL fr_spk_early: got %b expected 000", cur_speaker); end
    clk_cycle(1'b0);
    n_vec++; if (cur_speaker !== 3'b010 || gain !== 8'd0 || state_dbg !== S_FLUSH) begin
      n_err++; $display("FAIL fr_spk: got spk=%b gain=%0d st=%0d expected 010/0/%0d", cur_speaker, gain, state_dbg, S_FLUSH);
    end
    send_samples(63);
    n_vec++; if (state_dbg !== S_FLUSH) begin n_err++; $display("FAIL fr_restart63: got st=%0d expected %0d", state_dbg, S_FLUSH); end
    clk_cycle(1'b1);
    n_vec++; if (state_dbg !== S_FADE_IN) begin n_err++; $display("FAIL fr_restart64: got st=%0d expected %0d", state_dbg, S_FADE_IN); end
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    wait_state(S_RUN, 100, ok);
    n_vec++; if (!ok || gain !== 8'd255) begin n_err++; $display("FAIL fr_back: got ok=%b gain=%0d expected 1/255", ok, gain); end
  endtask

  task automatic test_mute();
    bit ok;
    req_mute = 1'b1;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    wait_state(S_FLUSH, 60, ok);
    n_vec++; if (!ok || cur_mute !== 1'b1 || gain !== 8'd0) begin
      n_err++; $display("FAIL mu_flush: got ok=%b cur=%b gain=%0d expected 1/1/0", ok, cur_mute, gain);
    end
    send_samples(63);
    clk_cycle(1'b1);
    n_vec++; if (state_dbg !== S_FADE_IN || gain !== 8'd0) begin n_err++; $display("FAIL mu_in: got st=%0d gain=%0d expected %0d/0", state_dbg, gain, S_FADE_IN); end
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_RUN || switch_done !== 1'b1 || gain !== 8'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mu_exit: got st=%0d done=%b gain=%0d busy=%b expected %0d/1/0/0", state_dbg, switch_done, gain, busy, S_RUN);
    end
    clk_cycle(1'b0);
    n_vec++; if (switch_done !== 1'b0 || gain !== 8'd0) begin n_err++; $display("FAIL mu_hold: got done=%b gain=%0d expected 0/0", switch_done, gain); end
    req_mute = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FLUSH || cur_mute !== 1'b0) begin n_err++; $display("FAIL mu_unmute: got st=%0d cur=%b expected %0d/0", state_dbg, cur_mute, S_FLUSH); end
    wait_state(S_RUN, 200, ok);
    n_vec++; if (!ok || gain !== 8'd255) begin n_err++; $display("FAIL mu_back: got ok=%b gain=%0d expected 1/255", ok, gain); end
  endtask

  task automatic test_abort();
    bit ok;
    int d0;
    logic [7:0] g_ab, e;
    g_ab = RAMP ? 8'd128 : 8'd0;
    req_separate1 = 1'b1;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    wait_state(S_FLUSH, 60, ok);
    send_samples(63);
    clk_cycle(1'b1);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    send_samples(RAMP ? 16 : 0);
    n_vec++; if (!ok || state_dbg !== S_FADE_IN || gain !== g_ab) begin
      n_err++; $display("FAIL ab_mid: got ok=%b st=%0d gain=%0d expected 1/%0d/%0d", ok, state_dbg, gain, S_FADE_IN, g_ab);
    end
    d0 = done_cnt;
    req_separate1 = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FADE_OUT || gain !== g_ab || cur_separate1 !== 1'b1) begin
      n_err++; $display("FAIL ab_turn: got st=%0d gain=%0d cur=%b expected %0d/%0d/1", state_dbg, gain, cur_separate1, S_FADE_OUT, g_ab);
    end
    for (int k = 1; k <= (RAMP ? 16 : 1); k++) begin
      e = exp_dn(128, k);
      clk_cycle(RAMP);
      n_vec++; if (gain !== e) begin n_err++; $display("FAIL ab_fade%0d: got %0d expected %0d", k, gain, e); end
      clk_cycle(1'b0);
      clk_cycle(1'b0);
    end
    n_vec++; if (state_dbg !== S_FLUSH || cur_separate1 !== 1'b0) begin
      n_err++; $display("FAIL ab_flush: got st=%0d cur=%b expected %0d/0", state_dbg, cur_separate1, S_FLUSH);
    end
    wait_state(S_RUN, 200, ok);
    n_vec++; if (!ok || done_cnt !== d0 + 1) begin n_err++; $display("FAIL ab_done: got ok=%b pulses=%0d expected 1/%0d", ok, done_cnt - d0, 1); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    req_denoise = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FADE_OUT) begin n_err++; $display("FAIL ra_start: got st=%0d expected %0d", state_dbg, S_FADE_OUT); end
    clk_cycle(1'b0);
    reset = 1'b1;
    clk_cycle(1'b0);
    n_vec++; if (state_dbg !== S_FLUSH || gain !== 8'd0 || busy !== 1'b1 || cur_word !== 9'd0) begin
      n_err++; $display("FAIL ra_values: got st=%0d gain=%0d busy=%b cur=%h expected %0d/0/1/0", state_dbg, gain, busy, cur_word, S_FLUSH);
    end
    reset = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    wait_state(S_RUN, 200, ok);
    n_vec++; if (!ok || cur_word !== 9'b010_0_1_0_0_0_0 || gain !== 8'd255) begin
      n_err++; $display("FAIL ra_recover: got ok=%b cur=%h gain=%0d expected 1/%h/255", ok, cur_word, gain, 9'b010_0_1_0_0_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_denoise();
    test_conflict();
    test_flush_restart();
    test_mute();
    test_abort();
    test_reset_abort();
    clk_cycle(1'b0);
    n_vec++; if (done_cnt !== 9) begin n_err++; $display("FAIL done_total: got %0d expected 9", done_cnt); end
    n_vec++; if (viol_cnt !== 0) begin n_err++; $display("FAIL cur_while_audible: got %0d expected 0", viol_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
